// File: rtl/imm_extend_pipe_if.sv
// Decode-to-execute immediate bus: upstream word handshake plus downstream result handshake.
// The slave modport is the immediate generator's view; master is the driver/consumer side.
interface imm_extend_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic [2:0]       in_fmt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_fmt, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_fmt, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// RISC-V immediate generator with a two-entry skid buffer, flush and a saturating counter
// of reserved-format words. in_ready is purely registered (no path from out_ready).
module imm_extend_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_extend_pipe_if.slave    bus,
    output logic [7:0]          err_count
);

    logic [31:7]      ins;
    logic [XLEN-1:0]  imm_new;
    logic             err_new;

    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_err_q, main_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_err_q, skid_err_d;
    logic [7:0]       err_count_q, err_count_d;

    logic accept;
    logic drain;

    assign ins    = bus.in_instr;
    assign accept = bus.in_valid & ~skid_valid_q;
    assign drain  = main_valid_q & bus.out_ready;

    // Sign-filled default, then the low field of each format overwrites the bottom bits.
    always_comb begin
        imm_new = {XLEN{ins[31]}};
        err_new = 1'b0;
        case (bus.in_fmt)
            3'b000: imm_new[11:0] = ins[31:20];
            3'b001: imm_new[11:0] = {ins[31:25], ins[11:7]};
            3'b010: imm_new[12:0] = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'b011: imm_new[20:0] = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'b100: imm_new[31:0] = {ins[31:12], 12'b0};
            3'b101: begin
                imm_new      = '0;
                imm_new[4:0] = ins[19:15];
            end
            3'b110: begin
                imm_new = '0;
                if (XLEN == 64) begin
                    imm_new[5:0] = ins[25:20];
                end else begin
                    imm_new[4:0] = ins[24:20];
                end
            end
            default: begin
                imm_new = '0;
                err_new = 1'b1;
            end
        endcase
    end

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        err_count_d  = err_count_q;

        // Counted on accept even if the same cycle flushes the word away.
        if (accept && err_new && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            main_valid_d = 1'b1;
            main_imm_d   = skid_imm_q;
            main_tag_d   = skid_tag_q;
            main_err_d   = skid_err_q;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            main_valid_d = accept;
            if (accept) begin
                main_imm_d = imm_new;
                main_tag_d = bus.in_tag;
                main_err_d = err_new;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = imm_new;
            skid_tag_d   = bus.in_tag;
            skid_err_d   = err_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.in_ready  = ~skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_imm   = main_imm_q;
    assign bus.out_tag   = main_tag_q;
    assign bus.out_err   = main_err_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Drives identical streams into XLEN=64 and XLEN=32 instances; a negedge monitor compares both
// against an arithmetic immediate model and a FIFO scoreboard of accepted words.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  in_fmt;
    logic [4:0]  in_tag;
    logic        out_ready;
    logic [7:0]  ec64, ec32;
    bit          chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   err_model = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();
    imm_extend_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();

    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_fmt    = in_fmt;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_fmt    = in_fmt;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus64.slave),
        .err_count (ec64)
    );

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus32.slave),
        .err_count (ec32)
    );

    // Immediate value as a weighted sum of instruction fields; the sign bit carries negative weight.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] fmt,
                                            input int xlen);
        longint v;
        case (fmt)
            3'd0: v = longint'(ins[30:20]) - (ins[31] ? 64'sd2048 : 64'sd0);
            3'd1: v = longint'(ins[30:25]) * 32 + longint'(ins[11:7])
                      - (ins[31] ? 64'sd2048 : 64'sd0);
            3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd3: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - (ins[31] ? 64'sd1048576 : 64'sd0);
            3'd4: v = longint'(ins[30:12]) * 4096 - (ins[31] ? 64'sd2147483648 : 64'sd0);
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        return (xlen == 64) ? v : {32'b0, v[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor and scoreboard: inputs are stable from posedge+1, so negedge sees the handshake.
    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        logic [31:0] full;
        if (chk_en) begin
            chk("out_valid64", bus64.out_valid, q.size() > 0);
            chk("out_valid32", bus32.out_valid, q.size() > 0);
            chk("in_ready64", bus64.in_ready, q.size() < 2);
            chk("in_ready32", bus32.in_ready, q.size() < 2);
            if (q.size() > 0) begin
                chk("imm64", bus64.out_imm, q[0].imm64);
                chk("imm32", bus32.out_imm, q[0].imm32);
                chk("tag64", bus64.out_tag, q[0].tag);
                chk("tag32", bus32.out_tag, q[0].tag);
                chk("err64", bus64.out_err, q[0].err);
                chk("err32", bus32.out_err, q[0].err);
            end
            chk("err_count64", ec64, err_model);
            chk("err_count32", ec32, err_model);
        end
        if (!rst_n) begin
            q.delete();
            err_model = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc && in_fmt == 3'd7 && err_model < 255) err_model++;
            if (flush) begin
                q.delete();
            end else if (acc) begin
                full    = {in_instr, 7'b0};
                e.imm64 = ref_imm(full, in_fmt, 64);
                e.imm32 = ref_imm(full, in_fmt, 32);
                e.tag   = in_tag;
                e.err   = (in_fmt == 3'd7);
                q.push_back(e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [2:0] fmt,
                          input logic [4:0] tag);
        in_valid = v;
        in_instr = ins[31:7];
        in_fmt   = fmt;
        in_tag   = tag;
    endtask

    logic [31:0] dv_ins [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h800000B7,
                                32'h02009093, 32'h000F8073, 32'hFFFFFFFF};
    logic [2:0]  dv_fmt [6] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [63:0] dv_e64 [6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
                                64'h20, 64'h1F, 64'h0};
    logic [31:0] dv_e32 [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h80000000,
                                32'h0, 32'h1F, 32'h0};

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'h0, 3'd0, 5'd0);
        repeat (2) cyc();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", bus64.out_valid, 1'b0);
        chk("rst_out_imm", bus64.out_imm, 64'h0);
        chk("rst_out_tag", bus64.out_tag, 5'd0);
        chk("rst_out_err", bus64.out_err, 1'b0);
        chk("rst_err_count", ec64, 8'd0);
        chk("rst_in_ready", bus64.in_ready, 1'b1);

        // Directed format vectors, one-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            set_in(1'b1, dv_ins[i], dv_fmt[i], 5'(i));
            cyc();
            set_in(1'b0, 32'h0, 3'd0, 5'd0);
            @(negedge clk);
            chk("dir_valid", bus64.out_valid, 1'b1);
            chk("dir_imm64", bus64.out_imm, dv_e64[i]);
            chk("dir_imm32", bus32.out_imm, dv_e32[i]);
            chk("dir_err", bus64.out_err, dv_fmt[i] == 3'd7);
        end
        cyc();

        // Backpressure: two absorbed, third held, then gapless 1,2,3.
        out_ready = 1'b0;
        set_in(1'b1, $urandom, 3'd0, 5'd1);
        cyc();
        set_in(1'b1, $urandom, 3'd1, 5'd2);
        cyc();
        set_in(1'b1, $urandom, 3'd2, 5'd3);
        @(negedge clk);
        chk("bp_in_ready_low", bus64.in_ready, 1'b0);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_seq1", {bus64.out_valid, bus64.out_tag}, {1'b1, 5'd1});
        cyc();
        @(negedge clk);
        chk("bp_seq2", {bus64.out_valid, bus64.out_tag}, {1'b1, 5'd2});
        cyc();
        set_in(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("bp_seq3", {bus64.out_valid, bus64.out_tag}, {1'b1, 5'd3});
        cyc();

        // Flush with both entries full and a word on offer.
        out_ready = 1'b0;
        set_in(1'b1, $urandom, 3'd3, 5'd10);
        cyc();
        set_in(1'b1, $urandom, 3'd4, 5'd11);
        cyc();
        set_in(1'b1, $urandom, 3'd5, 5'd12);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("flush_out_valid", bus64.out_valid, 1'b0);
        chk("flush_in_ready", bus64.in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Randomised traffic with backpressure, flushes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)));
            out_ready = $urandom_range(0, 9) < 6;
            flush     = $urandom_range(0, 31) == 0;
            rst_n     = $urandom_range(0, 199) != 0;
            cyc();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 32'h0, 3'd0, 5'd0);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Reserved format saturation.
        for (int i = 0; i < 300; i++) begin
            set_in(1'b1, $urandom, 3'd7, 5'(i));
            cyc();
        end
        set_in(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("err_sat", ec64, 8'd255);
        cyc();

        // Reset with the buffer full.
        out_ready = 1'b0;
        set_in(1'b1, $urandom, 3'd7, 5'd20);
        cyc();
        set_in(1'b1, $urandom, 3'd0, 5'd21);
        cyc();
        rst_n = 1'b0;
        set_in(1'b1, $urandom, 3'd1, 5'd22);
        cyc();
        rst_n = 1'b1;
        set_in(1'b0, 32'h0, 3'd0, 5'd0);
        @(negedge clk);
        chk("mrst_out_valid", bus64.out_valid, 1'b0);
        chk("mrst_out_imm", bus64.out_imm, 64'h0);
        chk("mrst_out_tag", bus64.out_tag, 5'd0);
        chk("mrst_out_err", bus64.out_err, 1'b0);
        chk("mrst_err_count", ec64, 8'd0);
        chk("mrst_in_ready", bus64.in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate generator for the decode→execute boundary of the 5-stage RISC-V core. It accepts instruction bits [31:7] plus a 3-bit format selector and produces an XLEN-wide immediate, registered. It adds U-type, CSR zimm, shift-amount and reserved-format handling, a valid/ready skid buffer so decode can be stalled without a combinational ready path, flush support, and a saturating error counter.

## Interface
- XLEN, 32, datapath width; legal values are 32 or 64.
- TAG_W, 5, width of a sideband tag (e.g. rd index) carried alongside the immediate.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_instr  input  25  instruction bits [31:7]; in_instr[i-7] = Instr[i].
- in_fmt  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SH, 111 reserved.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag accompanying out_imm.
- out_err  output  1  word was encoded with the reserved format.
- err_count  output  8  saturating count of accepted reserved-format words.

## Operation
- Immediate formation (combinational, before the registers). Below, s = Instr[31] replicated to XLEN bits:
  - I: sext(Instr[31:20]).
  - S: sext({Instr[31:25], Instr[11:7]}).
  - B: sext({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}).
  - J: sext({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}).
  - U: sext({Instr[31:12], 12'b0}). For XLEN=64, bits [63:32] = Instr[31].
  - Z: zext(Instr[19:15]), the CSR uimm.
  - SH: zext(Instr[24:20]) when XLEN=32; zext(Instr[25:20]) when XLEN=64.
  - 111: immediate = 0 and err = 1. For every other format err = 0.
- Buffering is a two-entry skid buffer: a main register (drives the out_* ports) and a skid register.
- in_ready = NOT skid_valid. It is a register output with no combinational path from out_ready.
- Accept occurs when in_valid & in_ready. Drain occurs when out_valid & out_ready.
- Per-cycle update when flush = 0:
  - Main empty, or main draining with skid empty: an accepted word loads main.
  - Main full, not draining, skid empty: an accepted word loads skid.
  - Main draining with skid full: skid moves to main. No accept is possible, because in_ready = 0.
- Ordering is strict FIFO; no word is ever lost or duplicated.
- flush = 1: main_valid and skid_valid clear at the next edge. Any word offered in the same cycle is discarded. out_imm, out_tag and out_err hold their stale values.
- err_count increments by 1 on each accepted word with fmt = 111, saturates at 255, and is cleared only by reset. A flushed word still counts if it was accepted.

## Timing
- Reset, with rst_n = 0 sampled at an edge:
  - out_valid = 0, out_imm = 0, out_tag = 0, out_err = 0, err_count = 0.
  - skid buffer empty, so in_ready = 1 from the cycle after reset.
  - Handshakes in reset cycles are ignored.
- Reset asserted mid-operation discards all buffered words.
- Latency: a word accepted at edge N is on out_* with out_valid = 1 after edge N.
- Throughput is 1 word per cycle while out_ready = 1.
- With out_ready held low, 2 words are absorbed. in_ready falls the cycle after the second accept.
- in_ready rises the cycle after the skid entry moves into main.
- out_* are stable while out_valid & ~out_ready. They change only on drain, on flush (valid only), or on reset.
- Simultaneous flush and reset: reset wins; the result is identical.

## Test plan
- I/B, XLEN=32: Instr 0xFFF00093 with fmt 000 → out_imm 0xFFFFFFFF one cycle after accept. Instr 0xFE000EE3 with fmt 010 → 0xFFFFFFFC.
- U/SH, XLEN=64: Instr 0x800000B7 with fmt 100 → 0xFFFFFFFF80000000. Instr 0x02009093 with fmt 110 → 0x20. Z with Instr[19:15] = 5'h1F → 0x1F.
- Backpressure: hold out_ready = 0 and offer tags 1, 2, 3 on consecutive cycles → tags 1 and 2 accepted, in_ready = 0, tag 3 held upstream. Then release → out_tag sequence 1, 2, 3 on consecutive cycles with no gaps.
- Flush: main and skid full, in_valid = 1, flush = 1 → next cycle out_valid = 0, in_ready = 1, and no flushed tag ever appears.
- Reserved format: 300 accepted words with fmt 111 → out_imm 0, out_err 1 on each, and err_count ends at 255.
- Reset mid-stream: rst_n low for one cycle with the buffer full → all outputs 0 and in_ready = 1 afterwards, with none of the old words emitted.
